// File: rtl/i2c_target_if.sv
// Fabric-side handshake of the I2C target: write-byte delivery, read-byte
// request/response, and bus event/status flags.
interface i2c_target_if;
    logic [7:0] tx_data;
    logic       tx_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       start_det;
    logic       stop_det;
    logic       busy;

    modport slave (
        input  tx_data,
        output tx_req, rx_data, rx_valid, start_det, stop_det, busy
    );

    modport master (
        output tx_data,
        input  tx_req, rx_data, rx_valid, start_det, stop_det, busy
    );
endinterface

// File: rtl/i2c_target.sv
// I2C target answering one 7-bit address; write bytes go out as rx pulses, read bytes come in via tx_req/tx_data.
// Optional macro I2C_TARGET_GLITCH_FILTER_EN adds a FILTER_LEN-cycle stability filter on scl/sda.
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h52,
    parameter int         FILTER_LEN  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scl,
    inout  wire           sda,
    i2c_target_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_IGNORE
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_scl_sync, r_sda_sync;
    logic        r_scl_prev, r_sda_prev;
    logic        w_scl, w_sda;
    logic        w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [2:0]  r_bit_cnt;
    logic [6:0]  r_shreg;
    logic [7:0]  w_byte;
    logic        w_addr_match;
    logic        r_rw, r_sda_low, r_ack_ph, r_byte_done;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid, r_tx_req, r_start_det, r_stop_det;
    logic        w_busy;

    // Reset to 1 so an idle bus produces no spurious edges after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
        end else begin
            r_scl_sync <= {r_scl_sync[0], scl};
            r_sda_sync <= {r_sda_sync[0], sda};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    logic [CNT_W-1:0] r_scl_cnt, r_sda_cnt;
    logic             r_scl_flt, r_sda_flt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_cnt <= '0;
            r_sda_cnt <= '0;
            r_scl_flt <= 1'b1;
            r_sda_flt <= 1'b1;
        end else begin
            if (r_scl_sync[1] == r_scl_flt) begin
                r_scl_cnt <= '0;
            end else if (r_scl_cnt == CNT_W'(FILTER_LEN - 1)) begin
                r_scl_flt <= r_scl_sync[1];
                r_scl_cnt <= '0;
            end else begin
                r_scl_cnt <= r_scl_cnt + 1'b1;
            end
            if (r_sda_sync[1] == r_sda_flt) begin
                r_sda_cnt <= '0;
            end else if (r_sda_cnt == CNT_W'(FILTER_LEN - 1)) begin
                r_sda_flt <= r_sda_sync[1];
                r_sda_cnt <= '0;
            end else begin
                r_sda_cnt <= r_sda_cnt + 1'b1;
            end
        end
    end

    assign w_scl = r_scl_flt;
    assign w_sda = r_sda_flt;
`else
    localparam int unused_filter_len = FILTER_LEN;
    assign w_scl = r_scl_sync[1];
    assign w_sda = r_sda_sync[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    assign w_scl_rise   = w_scl & ~r_scl_prev;
    assign w_scl_fall   = ~w_scl & r_scl_prev;
    assign w_start      = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
    assign w_stop       = w_scl & r_scl_prev & ~r_sda_prev & w_sda;
    assign w_byte       = {r_shreg, w_sda};
    assign w_addr_match = (r_shreg == TARGET_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_start) begin
            w_state_nxt = S_ADDR;
        end else if (w_stop) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_ADDR:      if (w_scl_rise && r_bit_cnt == 3'd7)
                                 w_state_nxt = w_addr_match ? S_ADDR_ACK : S_IGNORE;
                S_ADDR_ACK:  if (w_scl_fall && r_ack_ph)
                                 w_state_nxt = r_rw ? S_READ : S_WRITE;
                S_WRITE:     if (w_scl_rise && r_bit_cnt == 3'd7) w_state_nxt = S_WRITE_ACK;
                S_WRITE_ACK: if (w_scl_fall && r_ack_ph) w_state_nxt = S_WRITE;
                S_READ:      if (w_scl_fall && r_byte_done) w_state_nxt = S_READ_ACK;
                S_READ_ACK: begin
                    if (w_scl_rise && w_sda)           w_state_nxt = S_IGNORE;
                    else if (w_scl_fall && r_ack_ph)   w_state_nxt = S_READ;
                end
                default:     w_state_nxt = r_state;
            endcase
        end
    end

    // Datapath: shift register, bit counter, ACK phase and the sda pull-down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt   <= 3'd0;
            r_shreg     <= 7'd0;
            r_rw        <= 1'b0;
            r_sda_low   <= 1'b0;
            r_ack_ph    <= 1'b0;
            r_byte_done <= 1'b0;
            r_rx_data   <= 8'd0;
            r_rx_valid  <= 1'b0;
            r_tx_req    <= 1'b0;
            r_start_det <= 1'b0;
            r_stop_det  <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_tx_req    <= 1'b0;
            r_start_det <= 1'b0;
            r_stop_det  <= 1'b0;
            if (w_start) begin
                r_start_det <= 1'b1;
                r_bit_cnt   <= 3'd0;
                r_sda_low   <= 1'b0;
                r_ack_ph    <= 1'b0;
                r_byte_done <= 1'b0;
            end else if (w_stop) begin
                r_stop_det  <= 1'b1;
                r_sda_low   <= 1'b0;
                r_ack_ph    <= 1'b0;
                r_byte_done <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR, S_WRITE: begin
                        if (w_scl_rise) begin
                            r_shreg   <= w_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7 && r_state == S_ADDR && w_addr_match)
                                r_rw <= w_sda;
                            if (r_bit_cnt == 3'd7 && r_state == S_WRITE) begin
                                r_rx_data  <= w_byte;
                                r_rx_valid <= 1'b1;
                            end
                        end
                    end
                    S_ADDR_ACK, S_WRITE_ACK: begin
                        if (w_scl_fall && !r_ack_ph) begin
                            r_sda_low <= 1'b1;
                            r_ack_ph  <= 1'b1;
                            r_tx_req  <= (r_state == S_ADDR_ACK) && r_rw;
                        end else if (w_scl_fall) begin
                            r_ack_ph  <= 1'b0;
                            r_bit_cnt <= 3'd0;
                            if (r_state == S_ADDR_ACK && r_rw) begin
                                r_shreg   <= bus.tx_data[6:0];
                                r_sda_low <= ~bus.tx_data[7];
                            end else begin
                                r_sda_low <= 1'b0;
                            end
                        end
                    end
                    S_READ: begin
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) r_byte_done <= 1'b1;
                        end else if (w_scl_fall) begin
                            if (r_byte_done) begin
                                r_sda_low   <= 1'b0;
                                r_byte_done <= 1'b0;
                            end else begin
                                r_sda_low <= ~r_shreg[6];
                                r_shreg   <= {r_shreg[5:0], 1'b0};
                            end
                        end
                    end
                    S_READ_ACK: begin
                        if (w_scl_rise && !w_sda) begin
                            r_tx_req <= 1'b1;
                            r_ack_ph <= 1'b1;
                        end else if (w_scl_fall && r_ack_ph) begin
                            r_ack_ph  <= 1'b0;
                            r_bit_cnt <= 3'd0;
                            r_shreg   <= bus.tx_data[6:0];
                            r_sda_low <= ~bus.tx_data[7];
                        end
                    end
                    default: r_sda_low <= 1'b0;
                endcase
            end
        end
    end

    always_comb begin
        w_busy = 1'b0;
        case (r_state)
            S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK: w_busy = 1'b1;
            default: w_busy = 1'b0;
        endcase
    end

    // Driven from a reset-cleared register, so reset releases the line at once.
    assign sda           = r_sda_low ? 1'b0 : 1'bz;
    assign bus.busy      = w_busy;
    assign bus.rx_data   = r_rx_data;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.tx_req    = r_tx_req;
    assign bus.start_det = r_start_det;
    assign bus.stop_det  = r_stop_det;

endmodule
